display_mux_7seg: RTL and testbench

- Parametrised multi-digit 7-segment driver and successor to the single-digit BCD decoder.
- Time-multiplexes N_DIGITS common-anode digits on one shared segment bus.
- Per-digit features: decimal/hex decode, decimal-point control and blank enable.
- Inputs are double-buffered (pending/active) so a frame never tears mid-scan. Sits between the DPWM datapath/formatting logic and the board display pins.

---
 rtl/display_mux_7seg_if.sv | 25 ++
 rtl/display_mux_7seg.sv | 163 ++++++++++++++++
 tb/tb_display_mux_7seg.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/display_mux_7seg_if.sv
// Bus between the formatting logic and the multiplexed 7-segment driver.
// The master side writes digit data with a load strobe; the slave side
// (the driver) returns the registered segment/anode pins and a frame pulse.
interface display_mux_7seg_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] valores;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   habilitar;
  logic                  modo_hex;
  logic                  load;
  logic [7:0]            segmentos;
  logic [N_DIGITS-1:0]   anodos;
  logic                  frame_done;

  modport master (
    output valores, dp, habilitar, modo_hex, load,
    input  segmentos, anodos, frame_done
  );

  modport slave (
    input  valores, dp, habilitar, modo_hex, load,
    output segmentos, anodos, frame_done
  );
endinterface

// File: rtl/display_mux_7seg.sv
// Time-multiplexed common-anode 7-segment driver for N_DIGITS digits.
// Digit data is double-buffered: load writes the pending copy and the
// active copy is only replaced at a frame boundary, so a scan never tears.
// Each digit slot starts with BLANK cycles of all anodes off while the
// segment bus already carries the new digit, which suppresses ghosting.
module display_mux_7seg #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter int DIV_W    = 16,
  parameter int BLANK    = 4
) (
  input  logic               CLK,
  input  logic               reset,
  display_mux_7seg_if.slave  bus
);

  localparam int                  IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]    IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [DIV_W-1:0]    CNT_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0]    CNT_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]    CNT_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]    CNT_BLANK = DIV_W'(BLANK);
  localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{1'b1}};
  localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);
  localparam logic [N_DIGITS-1:0] DIG_ZERO  = {N_DIGITS{1'b0}};
  localparam logic [4*N_DIGITS-1:0] VAL_ZERO = {(4*N_DIGITS){1'b0}};

  // Active-low a..g pattern for one nibble; letters only in hex mode,
  // otherwise 10..15 are shown dark.
  function automatic logic [6:0] decode_nibble(input logic [3:0] nib, input logic hex);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = hex ? 7'b0001000 : 7'b1111111;
      4'hB:    seg = hex ? 7'b1100000 : 7'b1111111;
      4'hC:    seg = hex ? 7'b0110001 : 7'b1111111;
      4'hD:    seg = hex ? 7'b1000010 : 7'b1111111;
      4'hE:    seg = hex ? 7'b0110000 : 7'b1111111;
      4'hF:    seg = hex ? 7'b0111000 : 7'b1111111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [DIV_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;

  logic [4*N_DIGITS-1:0] pend_val_r;
  logic [N_DIGITS-1:0]   pend_dp_r;
  logic [N_DIGITS-1:0]   pend_hab_r;
  logic                  pend_hex_r;

  logic [4*N_DIGITS-1:0] act_val_r;
  logic [N_DIGITS-1:0]   act_dp_r;
  logic [N_DIGITS-1:0]   act_hab_r;
  logic                  act_hex_r;

  logic [7:0]            segmentos_r;
  logic [N_DIGITS-1:0]   anodos_r;
  logic                  frame_done_r;

  logic                  tick_s;
  logic                  frame_s;
  logic [3:0]            nib_s;
  logic                  hab_s;
  logic                  dp_s;
  logic [N_DIGITS-1:0]   an_next_s;
  logic [7:0]            seg_next_s;

  // Slot timing, current digit selection and the next pin values.
  always_comb begin
    tick_s     = (cnt_r == CNT_LAST);
    frame_s    = tick_s && (idx_r == IDX_LAST);
    nib_s      = act_val_r[{idx_r, 2'b00} +: 4];
    hab_s      = act_hab_r[idx_r];
    dp_s       = act_dp_r[idx_r];
    an_next_s  = AN_OFF;
    seg_next_s = 8'hFF;
    if (hab_s && (cnt_r >= CNT_BLANK)) begin
      an_next_s = ~(AN_ONE << idx_r);
    end else begin
      an_next_s = AN_OFF;
    end
    if (hab_s) begin
      seg_next_s = {~dp_s, decode_nibble(nib_s, act_hex_r)};
    end else begin
      seg_next_s = 8'hFF;
    end
  end

  // Slot counter and digit index; the index advances once per slot.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      cnt_r <= CNT_ZERO;
      idx_r <= IDX_ZERO;
    end else if (tick_s) begin
      cnt_r <= CNT_ZERO;
      idx_r <= (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Pending copy: every load overwrites it, last write wins.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      pend_val_r <= VAL_ZERO;
      pend_dp_r  <= DIG_ZERO;
      pend_hab_r <= DIG_ZERO;
      pend_hex_r <= 1'b0;
    end else if (bus.load) begin
      pend_val_r <= bus.valores;
      pend_dp_r  <= bus.dp;
      pend_hab_r <= bus.habilitar;
      pend_hex_r <= bus.modo_hex;
    end
  end

  // Active copy swaps at the frame boundary; a load on that same cycle
  // bypasses pending so it is not lost for a whole frame.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      act_val_r <= VAL_ZERO;
      act_dp_r  <= DIG_ZERO;
      act_hab_r <= DIG_ZERO;
      act_hex_r <= 1'b0;
    end else if (frame_s) begin
      act_val_r <= bus.load ? bus.valores   : pend_val_r;
      act_dp_r  <= bus.load ? bus.dp        : pend_dp_r;
      act_hab_r <= bus.load ? bus.habilitar : pend_hab_r;
      act_hex_r <= bus.load ? bus.modo_hex  : pend_hex_r;
    end
  end

  // Registered pins: one cycle behind the slot state, no input-to-output path.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      segmentos_r  <= 8'hFF;
      anodos_r     <= AN_OFF;
      frame_done_r <= 1'b0;
    end else begin
      segmentos_r  <= seg_next_s;
      anodos_r     <= an_next_s;
      frame_done_r <= frame_s;
    end
  end

  assign bus.segmentos  = segmentos_r;
  assign bus.anodos     = anodos_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Randomised and directed bench for display_mux_7seg with a frame-position
// reference model compared on every cycle, plus literal pin expectations.
module tb_display_mux_7seg;
  localparam int ND = 4;
  localparam int DV = 8;
  localparam int BK = 2;
  localparam int FR = ND * DV;

  logic CLK = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  display_mux_7seg_if #(.N_DIGITS(ND)) bus();

  display_mux_7seg #(.N_DIGITS(ND), .DIV(DV), .DIV_W(4), .BLANK(BK)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Decode table {dp,a..g} with dp dark, straight from the digit shapes.
  logic [7:0] seg_tbl [16];

  // Reference model: position within the frame plus pending/active copies.
  int         pos;
  bit         mvalid = 1'b0;
  logic [15:0] pv, av;
  logic [3:0]  pd, ad, ph, ah;
  logic        px, ax;
  logic [7:0]  m_seg;
  logic [3:0]  m_an;
  logic        m_fd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    int d, o, n;
    if (!reset) begin
      pos = 0; pv = 16'h0; av = 16'h0; pd = 4'h0; ad = 4'h0;
      ph = 4'h0; ah = 4'h0; px = 1'b0; ax = 1'b0;
      m_seg = 8'hFF; m_an = 4'hF; m_fd = 1'b0; mvalid = 1'b1;
    end else begin
      d = pos / DV;
      o = pos % DV;
      if (!ah[d]) begin
        m_seg = 8'hFF;
        m_an  = 4'hF;
      end else begin
        n = int'(av[4*d +: 4]);
        m_seg = {~ad[d], ((n < 10) || ax) ? seg_tbl[n][6:0] : 7'h7F};
        m_an  = (o < BK) ? 4'hF : ~(4'b0001 << d);
      end
      m_fd = (pos == FR - 1);
      if (bus.load) begin
        pv = bus.valores; pd = bus.dp; ph = bus.habilitar; px = bus.modo_hex;
      end
      if (pos == FR - 1) begin
        av = pv; ad = pd; ah = ph; ax = px;
      end
      pos = (pos + 1) % FR;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (mvalid) begin
      chk("model_seg", {24'h0, bus.segmentos}, {24'h0, m_seg});
      chk("model_an",  {28'h0, bus.anodos},    {28'h0, m_an});
      chk("model_fd",  {31'h0, bus.frame_done}, {31'h0, m_fd});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load_vals(input logic [15:0] v, input logic [3:0] d, input logic [3:0] h, input logic x);
    bus.valores = v; bus.dp = d; bus.habilitar = h; bus.modo_hex = x; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 100);
    chk("frame_done_seen", {31'h0, bus.frame_done}, 32'h1);
  endtask

  // Walks one whole frame after the next frame_done pulse.
  task automatic frame_literals(input string nm, input logic [31:0] segs, input logic [15:0] ans);
    wait_fd();
    for (int d = 0; d < ND; d++) begin
      for (int o = 0; o < DV; o++) begin
        step(1);
        if (o == 0) chk({nm, "_blank_an"}, {28'h0, bus.anodos}, 32'hF);
        if (o == BK) begin
          chk({nm, "_an"},  {28'h0, bus.anodos},    {28'h0, ans[4*d +: 4]});
          chk({nm, "_seg"}, {24'h0, bus.segmentos}, {24'h0, segs[8*d +: 8]});
        end
      end
    end
    chk({nm, "_period"}, {31'h0, bus.frame_done}, 32'h1);
  endtask

  initial begin
    bit fd_early;
    seg_tbl[0]  = 8'b10000001; seg_tbl[1]  = 8'b11001111;
    seg_tbl[2]  = 8'b10010010; seg_tbl[3]  = 8'b10000110;
    seg_tbl[4]  = 8'b11001100; seg_tbl[5]  = 8'b10100100;
    seg_tbl[6]  = 8'b10100000; seg_tbl[7]  = 8'b10001111;
    seg_tbl[8]  = 8'b10000000; seg_tbl[9]  = 8'b10000100;
    seg_tbl[10] = 8'b10001000; seg_tbl[11] = 8'b11100000;
    seg_tbl[12] = 8'b10110001; seg_tbl[13] = 8'b11000010;
    seg_tbl[14] = 8'b10110000; seg_tbl[15] = 8'b10111000;

    // Reset with a load that must be discarded.
    reset = 1'b0;
    bus.valores = 16'h9876; bus.dp = 4'hF; bus.habilitar = 4'hF;
    bus.modo_hex = 1'b1; bus.load = 1'b1;
    step(3);
    chk("rst_seg", {24'h0, bus.segmentos}, 32'hFF);
    chk("rst_an",  {28'h0, bus.anodos},    32'hF);
    chk("rst_fd",  {31'h0, bus.frame_done}, 32'h0);
    reset = 1'b1;
    bus.load = 1'b0;
    frame_literals("rst_frame", 32'hFFFFFFFF, 16'hFFFF);

    // Plain decimal scan.
    load_vals(16'h4321, 4'h0, 4'hF, 1'b0);
    frame_literals("scan", {8'hCC, 8'h86, 8'h92, 8'hCF}, 16'h7BDE);

    // Hex letters, then the same nibbles in decimal mode go dark.
    load_vals(16'hFEDA, 4'h0, 4'hF, 1'b1);
    frame_literals("hex", {8'hB8, 8'hB0, 8'hC2, 8'h88}, 16'h7BDE);
    load_vals(16'hFEDA, 4'h0, 4'hF, 1'b0);
    frame_literals("dec_dark", 32'hFFFFFFFF, 16'h7BDE);

    // Blanked digits and decimal point.
    load_vals(16'h8888, 4'b0010, 4'b1010, 1'b0);
    frame_literals("blank_dp", {8'h80, 8'hFF, 8'h00, 8'hFF}, 16'h7FDF);

    // Load in the digit-1 slot must not affect digits 2/3 of this frame.
    load_vals(16'h4321, 4'h0, 4'hF, 1'b0);
    wait_fd();
    step(11);
    load_vals(16'h8888, 4'h0, 4'hF, 1'b0);
    step(7);
    chk("tear_old_seg", {24'h0, bus.segmentos}, 32'h86);
    chk("tear_old_an",  {28'h0, bus.anodos},    32'hB);
    wait_fd();
    step(3);
    chk("tear_new_seg", {24'h0, bus.segmentos}, 32'h80);
    chk("tear_new_an",  {28'h0, bus.anodos},    32'hE);

    // Load exactly on the frame-boundary cycle.
    step(28);
    load_vals(16'h0000, 4'h0, 4'hF, 1'b0);
    chk("bnd_fd", {31'h0, bus.frame_done}, 32'h1);
    step(3);
    chk("bnd_seg", {24'h0, bus.segmentos}, 32'h81);
    chk("bnd_an",  {28'h0, bus.anodos},    32'hE);

    // One-cycle reset in the digit-2 slot.
    step(17);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("mid_rst_seg", {24'h0, bus.segmentos}, 32'hFF);
    chk("mid_rst_an",  {28'h0, bus.anodos},    32'hF);
    fd_early = 1'b0;
    for (int k = 0; k < FR - 1; k++) begin
      step(1);
      if (bus.frame_done !== 1'b0) fd_early = 1'b1;
    end
    chk("mid_rst_no_fd", {31'h0, fd_early}, 32'h0);
    step(1);
    chk("mid_rst_fd32", {31'h0, bus.frame_done}, 32'h1);

    // Random loads, contents and occasional resets against the model.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      bus.valores   = 16'($urandom);
      bus.dp        = 4'($urandom);
      bus.habilitar = 4'($urandom);
      bus.modo_hex  = 1'($urandom);
      bus.load      = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      step(1);
    end
    reset = 1'b1;
    bus.load = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
